// File: rtl/temp_ctrl_pkg.sv
// Shared definitions for the temperature-driven fan controller: state encodings,
// default parameter values and a counter-width helper.
package temp_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_PREVEN   = 2'b01,
        ST_CRITIC   = 2'b10,
        ST_COOLDOWN = 2'b11
    } state_e;

    localparam int FILT_CYCLES_DEF   = 4;
    localparam int MIN_ON_CYCLES_DEF = 16;
    localparam int BLINK_HALF_DEF    = 8;

    // $clog2 of 1 is 0, so clamp to one bit to keep counters legal at the minimum setting.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flag_filter.sv
// Two-flop synchroniser followed by a persistence filter: the output follows the
// synchronised input only after it has differed for FILT_CYCLES consecutive cycles.
module flag_filter
    import temp_ctrl_pkg::*;
#(
    parameter int FILT_CYCLES = FILT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic filt
);

    localparam int CW = $clog2(FILT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;

    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            filt_q  <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            filt_q  <= filt_d;
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/temp_fan_ctrl.sv
// Fan / alarm controller: filters the preventive and critical temperature flags and
// drives fan, LED and buzzer from a Moore FSM with fan run-on and LED blinking.
module temp_fan_ctrl
    import temp_ctrl_pkg::*;
#(
    parameter int FILT_CYCLES   = FILT_CYCLES_DEF,
    parameter int MIN_ON_CYCLES = MIN_ON_CYCLES_DEF,
    parameter int BLINK_HALF    = BLINK_HALF_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       TempPreven,
    input  logic       TempCritic,
    output logic       fan_on,
    output logic       alarm_led,
    output logic       alarm_buzzer,
    output logic [1:0] state_o
);

    localparam int CD_W = cnt_width(MIN_ON_CYCLES);
    localparam int BL_W = cnt_width(BLINK_HALF);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(MIN_ON_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

    logic pf, cf;

    flag_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_preven (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (TempPreven),
        .filt    (pf)
    );

    flag_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_critic (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (TempCritic),
        .filt    (cf)
    );

    state_e            state_q, state_d;
    logic [CD_W-1:0]   cd_cnt_q, cd_cnt_d;
    logic [BL_W-1:0]   bl_cnt_q, bl_cnt_d;
    logic              blink_q, blink_d;

    always_comb begin
        state_d  = state_q;
        cd_cnt_d = '0;
        bl_cnt_d = '0;
        blink_d  = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cf)      state_d = ST_CRITIC;
                    else if (pf) state_d = ST_PREVEN;
                end
                ST_PREVEN: begin
                    if (cf)       state_d = ST_CRITIC;
                    else if (!pf) state_d = ST_COOLDOWN;
                end
                ST_CRITIC: begin
                    if (!cf) state_d = pf ? ST_PREVEN : ST_COOLDOWN;
                end
                ST_COOLDOWN: begin
                    if (cf)                   state_d = ST_CRITIC;
                    else if (pf)              state_d = ST_PREVEN;
                    else if (cd_cnt_q == '0)  state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Staying in COOLDOWN implies the counter is non-zero, so the decrement cannot wrap.
        if (state_d == ST_COOLDOWN) begin
            cd_cnt_d = (state_q == ST_COOLDOWN) ? cd_cnt_q - 1'b1 : CD_LOAD;
        end

        if (state_d == ST_CRITIC) begin
            if (state_q != ST_CRITIC) begin
                blink_d = 1'b1;
            end else if (bl_cnt_q == BL_LAST) begin
                blink_d = ~blink_q;
            end else begin
                bl_cnt_d = bl_cnt_q + 1'b1;
                blink_d  = blink_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cd_cnt_q <= '0;
            bl_cnt_q <= '0;
            blink_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cd_cnt_q <= cd_cnt_d;
            bl_cnt_q <= bl_cnt_d;
            blink_q  <= blink_d;
        end
    end

    always_comb begin
        fan_on       = (state_q != ST_IDLE);
        alarm_led    = (state_q == ST_PREVEN) || ((state_q == ST_CRITIC) && blink_q);
        alarm_buzzer = (state_q == ST_CRITIC);
        state_o      = state_q;
    end

endmodule

// File: tb/tb_temp_fan_ctrl.sv
// Self-checking bench for temp_fan_ctrl: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the controller.
module tb_temp_fan_ctrl;

    localparam int FILT   = 4;
    localparam int MIN_ON = 16;
    localparam int BHALF  = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       TempPreven = 1'b0;
    logic       TempCritic = 1'b0;
    logic       fan_on, alarm_led, alarm_buzzer;
    logic [1:0] state_o;
    logic [4:0] obs;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    temp_fan_ctrl #(
        .FILT_CYCLES   (FILT),
        .MIN_ON_CYCLES (MIN_ON),
        .BLINK_HALF    (BHALF)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .TempPreven   (TempPreven),
        .TempCritic   (TempCritic),
        .fan_on       (fan_on),
        .alarm_led    (alarm_led),
        .alarm_buzzer (alarm_buzzer),
        .state_o      (state_o)
    );

    assign obs = {fan_on, alarm_led, alarm_buzzer, state_o};

    // Reference model: raw samples travel through a two-deep queue, each filtered flag
    // flips after FILT consecutive disagreeing samples, and the controller state is
    // tracked as an integer with cycles-in-cooldown and cycles-in-critic ages.
    bit p_pipe[$];
    bit c_pipe[$];
    bit p_sync, c_sync;
    bit m_pf, m_cf;
    int m_prun, m_crun;
    int m_state, m_next, m_cd, m_age;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_pipe.delete(); p_pipe.push_back(1'b0); p_pipe.push_back(1'b0);
            c_pipe.delete(); c_pipe.push_back(1'b0); c_pipe.push_back(1'b0);
            m_pf = 1'b0; m_cf = 1'b0; m_prun = 0; m_crun = 0;
            m_state = 0; m_cd = 0; m_age = 0;
        end else begin
            p_sync = p_pipe.pop_front(); p_pipe.push_back(TempPreven);
            c_sync = c_pipe.pop_front(); c_pipe.push_back(TempCritic);

            m_next = m_state;
            if (!enable) m_next = 0;
            else begin
                case (m_state)
                    0: if (m_cf) m_next = 2; else if (m_pf) m_next = 1;
                    1: if (m_cf) m_next = 2; else if (!m_pf) m_next = 3;
                    2: if (!m_cf) m_next = m_pf ? 1 : 3;
                    default: if (m_cf) m_next = 2; else if (m_pf) m_next = 1;
                             else if (m_cd >= MIN_ON) m_next = 0;
                endcase
            end
            m_cd  = (m_next == 3) ? ((m_state == 3) ? m_cd + 1 : 1) : 0;
            m_age = (m_next == 2 && m_state == 2) ? m_age + 1 : 0;
            m_state = m_next;

            m_prun = (p_sync != m_pf) ? m_prun + 1 : 0;
            if (m_prun == FILT) begin m_pf = p_sync; m_prun = 0; end
            m_crun = (c_sync != m_cf) ? m_crun + 1 : 0;
            if (m_crun == FILT) begin m_cf = c_sync; m_crun = 0; end
        end
    end

    function automatic logic [4:0] model_out();
        logic fan, led, buzz;
        fan  = (m_state != 0);
        buzz = (m_state == 2);
        led  = (m_state == 1) || ((m_state == 2) && ((m_age / BHALF) % 2 == 0));
        return {fan, led, buzz, 2'(m_state)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; enable = 1'b1; TempPreven = 1'b0; TempCritic = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            tick(1);
            found = (state_o === s);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1; TempPreven = 1'b0; TempCritic = 1'b0;
        #2;
        vectors++;
        if (obs !== 5'b00000) begin miscompares++; $display("[TB] FAIL reset_initial: got %b required 00000", obs); end
        TempPreven = 1'b1; TempCritic = 1'b1;
        tick(8);
        vectors++;
        if (obs !== 5'b00000) begin miscompares++; $display("[TB] FAIL reset_held: got %b required 00000", obs); end
        TempPreven = 1'b0; TempCritic = 1'b0; reset_n = 1'b1;
        tick(10);
        vectors++;
        if (obs !== 5'b00000) begin miscompares++; $display("[TB] FAIL reset_release: got %b required 00000", obs); end
        vectors++;
        if (obs !== model_out()) begin miscompares++; $display("[TB] FAIL reset_model: got %b required %b", obs, model_out()); end
    endtask

    task automatic test_preven_latency();
        logic [4:0] want;
        apply_reset();
        tick(3);
        TempPreven = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick(1);
            want = (e < 7) ? 5'b00000 : 5'b11001;
            vectors++;
            if (obs !== want) begin miscompares++; $display("[TB] FAIL preven_latency edge %0d: got %b required %b", e, obs, want); end
            vectors++;
            if (obs !== model_out()) begin miscompares++; $display("[TB] FAIL preven_model edge %0d: got %b required %b", e, obs, model_out()); end
        end
        #3 reset_n = 1'b0;
        #1;
        vectors++;
        if (obs !== 5'b00000) begin miscompares++; $display("[TB] FAIL async_reset: got %b required 00000", obs); end
        tick(1);
        TempPreven = 1'b0; reset_n = 1'b1;
    endtask

    task automatic test_short_pulse();
        apply_reset();
        tick(3);
        TempPreven = 1'b1;
        for (int c = 0; c < 15; c++) begin
            tick(1);
            if (c == 2) TempPreven = 1'b0;
            vectors++;
            if (obs !== 5'b00000) begin miscompares++; $display("[TB] FAIL short_pulse cycle %0d: got %b required 00000", c, obs); end
        end
    endtask

    task automatic test_cooldown();
        bit found;
        int cd_len;
        apply_reset();
        TempPreven = 1'b1;
        wait_state(2'b01, 12, found);
        TempPreven = 1'b0;
        wait_state(2'b11, 12, found);
        vectors++;
        if (!found) begin miscompares++; $display("[TB] FAIL cooldown_entry: state_o=%b required 11", state_o); end
        cd_len = 1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            vectors++;
            if (obs !== model_out()) begin miscompares++; $display("[TB] FAIL cooldown_model: got %b required %b", obs, model_out()); end
            if (state_o !== 2'b11) break;
            cd_len++;
        end
        vectors++;
        if (cd_len != MIN_ON) begin miscompares++; $display("[TB] FAIL cooldown_length: got %0d required %0d", cd_len, MIN_ON); end
        vectors++;
        if (obs !== 5'b00000) begin miscompares++; $display("[TB] FAIL cooldown_exit: got %b required 00000", obs); end

        TempPreven = 1'b1;
        wait_state(2'b01, 12, found);
        TempPreven = 1'b0;
        wait_state(2'b11, 12, found);
        tick(9);
        TempPreven = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick(1);
            vectors++;
            if (fan_on !== 1'b1) begin miscompares++; $display("[TB] FAIL cooldown_fan_hold: got %b required 1", fan_on); end
            found = (state_o === 2'b01);
        end
        vectors++;
        if (!found) begin miscompares++; $display("[TB] FAIL cooldown_reraise: state_o=%b required 01", state_o); end
    endtask

    task automatic test_critic();
        bit found;
        logic want_led;
        apply_reset();
        TempPreven = 1'b1; TempCritic = 1'b1;
        wait_state(2'b10, 12, found);
        vectors++;
        if (!found) begin miscompares++; $display("[TB] FAIL critic_entry: state_o=%b required 10", state_o); end
        for (int k = 0; k <= 2 * BHALF; k++) begin
            if (k > 0) tick(1);
            want_led = (k < BHALF) || (k == 2 * BHALF);
            vectors++;
            if (obs !== {1'b1, want_led, 1'b1, 2'b10}) begin
                miscompares++; $display("[TB] FAIL critic_blink k=%0d: got %b required %b", k, obs, {1'b1, want_led, 1'b1, 2'b10});
            end
        end
        TempCritic = 1'b0;
        wait_state(2'b01, 12, found);
        vectors++;
        if (obs !== 5'b11001) begin miscompares++; $display("[TB] FAIL critic_to_preven: got %b required 11001", obs); end
    endtask

    task automatic test_enable();
        bit found;
        apply_reset();
        TempPreven = 1'b1;
        wait_state(2'b01, 12, found);
        enable = 1'b0;
        tick(1);
        vectors++;
        if (obs !== 5'b00000) begin miscompares++; $display("[TB] FAIL enable_off: got %b required 00000", obs); end
        tick(3);
        vectors++;
        if (obs !== 5'b00000) begin miscompares++; $display("[TB] FAIL enable_held: got %b required 00000", obs); end
        enable = 1'b1;
        tick(1);
        vectors++;
        if (obs !== 5'b11001) begin miscompares++; $display("[TB] FAIL enable_on: got %b required 11001", obs); end
    endtask

    task automatic test_random();
        int hold;
        apply_reset();
        for (int it = 0; it < 250; it++) begin
            hold       = $urandom_range(1, 12);
            TempPreven = ($urandom_range(0, 2) != 0);
            TempCritic = ($urandom_range(0, 3) == 0);
            enable     = ($urandom_range(0, 9) != 0);
            for (int c = 0; c < hold; c++) begin
                tick(1);
                vectors++;
                if (obs !== model_out()) begin miscompares++; $display("[TB] FAIL random it=%0d: got %b required %b", it, obs, model_out()); end
            end
            if ($urandom_range(0, 59) == 0) begin
                #3 reset_n = 1'b0;
                #1;
                vectors++;
                if (obs !== 5'b00000) begin miscompares++; $display("[TB] FAIL random_reset: got %b required 00000", obs); end
                tick(1);
                reset_n = 1'b1;
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_preven_latency();
        test_short_pulse();
        test_cooldown();
        test_critic();
        test_enable();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
